// File: rtl/iob_fifo_sync_ext_if.sv
// Producer/consumer-facing bus of the extended synchronous FIFO.
// slave is the FIFO side, master is whoever drives writes, pops and thresholds.
interface iob_fifo_sync_ext_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 6
);
  logic                clr;
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                w_almost_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic                r_almost_empty;
  logic [ADDR_W:0]     af_thresh;
  logic [ADDR_W:0]     ae_thresh;
  logic [ADDR_W:0]     level;
  logic                overflow;
  logic                underflow;

  modport slave (
    input  clr, w_en, w_data, r_en, af_thresh, ae_thresh,
    output w_full, w_almost_full, r_data, r_empty, r_almost_empty, level, overflow, underflow
  );

  modport master (
    output clr, w_en, w_data, r_en, af_thresh, ae_thresh,
    input  w_full, w_almost_full, r_data, r_empty, r_almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/iob_fifo_sync_ext.sv
// Single-clock asymmetric-width FIFO; r_data one cycle after pop (FWFT=0) or head word shown
// through a two-stage prefetch (FWFT=1); full/empty drop requests and latch sticky error flags.
module iob_fifo_sync_ext #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 6,
  parameter int FWFT     = 0
) (
  input logic                 clk,
  input logic                 rst,
  iob_fifo_sync_ext_if.slave  bus
);
  localparam int MIN_W     = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_INCR    = W_DATA_W / MIN_W;
  localparam int R_INCR    = R_DATA_W / MIN_W;
  localparam int LVL_W     = ADDR_W + 1;
  localparam int FIFO_SIZE = 2 ** ADDR_W;

  localparam logic [LVL_W-1:0]  W_INC_L  = LVL_W'(W_INCR);
  localparam logic [LVL_W-1:0]  R_INC_L  = LVL_W'(R_INCR);
  localparam logic [LVL_W-1:0]  FULL_LIM = LVL_W'(FIFO_SIZE - W_INCR);
  localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(W_INCR);
  localparam logic [ADDR_W-1:0] R_STEP   = ADDR_W'(R_INCR);

  // Storage is kept in narrow units; pointers step by their port's ratio so they stay aligned.
  logic [MIN_W-1:0]    mem_q [FIFO_SIZE];

  logic [LVL_W-1:0]    level_q, level_d;
  logic [ADDR_W-1:0]   w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0]   r_ptr_q, r_ptr_d;
  logic [R_DATA_W-1:0] r_data_q, r_data_d;
  logic                out_vld_q, out_vld_d;
  logic                a_vld_q, a_vld_d;
  logic [R_DATA_W-1:0] a_dat_q, a_dat_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                w_full, r_empty;
  logic                w_en_int, r_en_int;
  logic                a_load, b_load, ram_rd;
  logic [LVL_W-1:0]    ram_lvl;
  logic [R_DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < R_INCR; i++) begin
      rd_word[i*MIN_W +: MIN_W] = mem_q[r_ptr_q + ADDR_W'(i)];
    end
  end

  assign w_full  = level_q > FULL_LIM;
  assign r_empty = (FWFT != 0) ? ~out_vld_q : (level_q < R_INC_L);
  // Words already pulled into the prefetch stages still count in level, so subtract them.
  assign ram_lvl = level_q - (out_vld_q ? R_INC_L : '0) - (a_vld_q ? R_INC_L : '0);

  always_comb begin
    w_en_int  = bus.w_en & ~w_full;
    r_en_int  = bus.r_en & ~r_empty;
    b_load    = 1'b0;
    a_load    = 1'b0;
    r_data_d  = r_data_q;
    out_vld_d = out_vld_q;
    a_vld_d   = a_vld_q;
    a_dat_d   = a_dat_q;

    if (FWFT != 0) begin
      // Stage A holds the RAM read, stage B is the visible head; both advance on a pop.
      b_load = a_vld_q & (~out_vld_q | r_en_int);
      a_load = (ram_lvl >= R_INC_L) & (~a_vld_q | b_load);
      if (b_load) begin
        r_data_d  = a_dat_q;
        out_vld_d = 1'b1;
      end else if (r_en_int) begin
        out_vld_d = 1'b0;
      end
      if (a_load) begin
        a_dat_d = rd_word;
        a_vld_d = 1'b1;
      end else if (b_load) begin
        a_vld_d = 1'b0;
      end
      ram_rd = a_load;
    end else begin
      if (r_en_int) r_data_d = rd_word;
      ram_rd = r_en_int;
    end

    level_d = level_q + (w_en_int ? W_INC_L : '0) - (r_en_int ? R_INC_L : '0);
    w_ptr_d = w_en_int ? w_ptr_q + W_STEP : w_ptr_q;
    r_ptr_d = ram_rd   ? r_ptr_q + R_STEP : r_ptr_q;
    ovf_d   = ovf_q | (bus.w_en & w_full);
    unf_d   = unf_q | (bus.r_en & r_empty);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      level_q   <= '0;
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      r_data_q  <= '0;
      out_vld_q <= 1'b0;
      a_vld_q   <= 1'b0;
      a_dat_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      r_data_q  <= r_data_d;
      out_vld_q <= out_vld_d;
      a_vld_q   <= a_vld_d;
      a_dat_q   <= a_dat_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en_int && !bus.clr && !rst) begin
      for (int i = 0; i < W_INCR; i++) begin
        mem_q[w_ptr_q + ADDR_W'(i)] <= bus.w_data[i*MIN_W +: MIN_W];
      end
    end
  end

  assign bus.w_full         = w_full;
  assign bus.w_almost_full  = level_q >= bus.af_thresh;
  assign bus.r_data         = r_data_q;
  assign bus.r_empty        = r_empty;
  assign bus.r_almost_empty = level_q <= bus.ae_thresh;
  assign bus.level          = level_q;
  assign bus.overflow       = ovf_q;
  assign bus.underflow      = unf_q;
endmodule
